moore_seq_detect: RTL and testbench



---
 rtl/seq_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 35 +++
 rtl/moore_seq_detect.sv | 81 ++++++++
 tb/tb_moore_seq_detect.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector and its counters.
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MAX = 32;

  // Bits needed to hold a history depth of 0..pat_w.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Increment that sticks at max_val instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
    return (val >= max_val) ? max_val : val + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count, held at all-ones once reached.
  always_comb begin
    q_d = W'(sat_inc(32'(q_q), 32'(MAX)));
  end

  // Count register; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= '0;
    end else if (inc) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/moore_seq_detect.sv
// Parametrised Moore serial pattern detector with qualifier, soft clear and
// saturating match counter.
module moore_seq_detect
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter              PATTERN = 4'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       clear,
  output logic                       out,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [fill_w(PAT_W)-1:0]   fill
);

  localparam int unsigned     FILL_W = fill_w(PAT_W);
  localparam logic [PAT_W-1:0] PAT   = PAT_W'(PATTERN);

  // Reject unsupported parameterisations at elaboration.
  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("moore_seq_detect: PAT_W must be in 2..16");
  end
  if ($bits(PATTERN) != PAT_W) begin : g_bad_pattern
    $error("moore_seq_detect: PATTERN width must equal PAT_W");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("moore_seq_detect: CNT_W must be in 1..32");
  end

  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              match_d;
  logic              cnt_inc;

  // Moore decode of registered state; the serial input never reaches out.
  assign out = (fill_q == FILL_W'(PAT_W)) && (hist_q == PAT);

  // Candidate next state assuming the current bit is accepted.
  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], in};
    if (!OVERLAP && out) begin
      // Bits of the current match are consumed; new bit opens a fresh window.
      fill_d = FILL_W'(1);
    end else begin
      fill_d = FILL_W'(sat_inc(32'(fill_q), PAT_W));
    end
    match_d = (fill_d == FILL_W'(PAT_W)) && (hist_d == PAT);
    cnt_inc = in_valid && !clear && match_d;
  end

  // History and fill registers; rst > clear > in_valid.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (clear),
    .q   (match_cnt)
  );

  assign fill = fill_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Self-checking bench: three detector variants share one stimulus stream and
// are compared against a stream-level reference model.
module tb_moore_seq_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_b;
  logic in_valid;
  logic clear;

  logic       out0, out1, out2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] fill0, fill1, fill2;

  // 0: overlapping 1011, 1: non-overlapping 1011, 2: overlapping 1111 with 2-bit counter
  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .clear(clear),
    .out(out0), .match_cnt(cnt0), .fill(fill0));

  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .clear(clear),
    .out(out1), .match_cnt(cnt1), .fill(fill1));

  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .clear(clear),
    .out(out2), .match_cnt(cnt2), .fill(fill2));

  logic       d_out[3];
  logic [7:0] d_cnt[3];
  logic [2:0] d_fill[3];

  always_comb begin
    d_out[0]  = out0;  d_out[1]  = out1;  d_out[2]  = out2;
    d_cnt[0]  = cnt0;  d_cnt[1]  = cnt1;  d_cnt[2]  = 8'(cnt2);
    d_fill[0] = fill0; d_fill[1] = fill1; d_fill[2] = fill2;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: list of accepted bits since reset/clear, plus per-variant
  // start of the window still eligible for matching.
  bit       acc[$];
  int       start[3];
  bit       m_out[3];
  int       m_cnt[3];
  bit [3:0] m_pat[3];
  bit       m_ov[3];
  int       m_max[3];

  localparam bit [6:0] S_A = 7'b1011011;
  localparam bit [7:0] S_B = 8'b10111011;

  function automatic int exp_fill(input int k);
    int n;
    n = acc.size() - start[k];
    return (n > 4) ? 4 : n;
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit v, input bit b);
    int  sz;
    bit  m;
    if (r || c) begin
      acc.delete();
      for (int k = 0; k < 3; k++) begin
        start[k] = 0; m_out[k] = 1'b0; m_cnt[k] = 0;
      end
    end else if (v) begin
      for (int k = 0; k < 3; k++)
        if (!m_ov[k] && m_out[k]) start[k] = acc.size();
      acc.push_back(b);
      sz = acc.size();
      for (int k = 0; k < 3; k++) begin
        m = (sz - start[k]) >= 4;
        if (m)
          for (int i = 0; i < 4; i++)
            if (acc[sz - 4 + i] != m_pat[k][3 - i]) m = 1'b0;
        m_out[k] = m;
        if (m && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input bit b);
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_b = b;
    @(posedge clk);
    model_edge(r, c, v, b);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_out[k] !== 1'b0 || d_cnt[k] !== 8'd0 || d_fill[k] !== 3'd0) begin
          failures++;
          $display("FAIL reset_hold[%0d] got out=%b cnt=%0d fill=%0d exp all 0", k, d_out[k], d_cnt[k], d_fill[k]);
        end
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'(i != 1));
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_fill[k] !== 3'(exp_fill(k))) begin
        failures++;
        $display("FAIL reset_partial_fill[%0d] got=%0d exp=%0d", k, d_fill[k], exp_fill(k));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_out[k] !== 1'b0 || d_cnt[k] !== 8'd0 || d_fill[k] !== 3'd0) begin
          failures++;
          $display("FAIL reset_mid[%0d] got out=%b cnt=%0d fill=%0d exp all 0", k, d_out[k], d_cnt[k], d_fill[k]);
        end
      end
    end
  endtask

  task automatic test_streams();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, S_A[6 - i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_out[k] !== m_out[k] || d_cnt[k] !== 8'(m_cnt[k]) || d_fill[k] !== 3'(exp_fill(k))) begin
          failures++;
          $display("FAIL stream_a[%0d] bit%0d got out=%b cnt=%0d fill=%0d exp out=%b cnt=%0d fill=%0d",
                   k, i + 1, d_out[k], d_cnt[k], d_fill[k], m_out[k], m_cnt[k], exp_fill(k));
        end
      end
      checks++;
      if (d_out[0] !== 1'(i == 3 || i == 6)) begin
        failures++;
        $display("FAIL stream_a_ov_out bit%0d got=%b exp=%b", i + 1, d_out[0], 1'(i == 3 || i == 6));
      end
    end
    checks++;
    if (d_cnt[0] !== 8'd2 || d_cnt[1] !== 8'd1) begin
      failures++;
      $display("FAIL stream_a_counts got ov=%0d nov=%0d exp ov=2 nov=1", d_cnt[0], d_cnt[1]);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, S_B[7 - i]);
      checks++;
      if (d_out[1] !== m_out[1] || d_cnt[1] !== 8'(m_cnt[1]) || d_fill[1] !== 3'(exp_fill(1))) begin
        failures++;
        $display("FAIL stream_b_nov bit%0d got out=%b cnt=%0d fill=%0d exp out=%b cnt=%0d fill=%0d",
                 i + 1, d_out[1], d_cnt[1], d_fill[1], m_out[1], m_cnt[1], exp_fill(1));
      end
    end
    checks++;
    if (d_cnt[1] !== 8'd2) begin
      failures++;
      $display("FAIL stream_b_nov_count got=%0d exp=2", d_cnt[1]);
    end
  endtask

  task automatic test_bubbles();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'(i != 1));
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (d_out[k] !== m_out[k] || d_cnt[k] !== 8'(m_cnt[k]) || d_fill[k] !== 3'(exp_fill(k))) begin
            failures++;
            $display("FAIL bubbles[%0d] bit%0d idle%0d got out=%b cnt=%0d exp out=%b cnt=%0d",
                     k, i + 1, j, d_out[k], d_cnt[k], m_out[k], m_cnt[k]);
          end
        end
        checks++;
        if (d_out[0] !== 1'(i == 3)) begin
          failures++;
          $display("FAIL bubbles_hold bit%0d idle%0d got=%b exp=%b", i + 1, j, d_out[0], 1'(i == 3));
        end
      end
    end
    checks++;
    if (d_cnt[0] !== 8'd1) begin
      failures++;
      $display("FAIL bubbles_count got=%0d exp=1", d_cnt[0]);
    end
  endtask

  task automatic test_saturation();
    int exp_c;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      exp_c = (i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
      checks++;
      if (d_cnt[2] !== 8'(exp_c) || d_out[2] !== 1'(i >= 4)) begin
        failures++;
        $display("FAIL saturation bit%0d got cnt=%0d out=%b exp cnt=%0d out=%b",
                 i, d_cnt[2], d_out[2], exp_c, 1'(i >= 4));
      end
      checks++;
      if (d_cnt[0] !== 8'd0) begin
        failures++;
        $display("FAIL saturation_other bit%0d got=%0d exp=0", i, d_cnt[0]);
      end
    end
  endtask

  task automatic test_clear_collision();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'(i != 1));
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_out[k] !== 1'b0 || d_cnt[k] !== 8'd0 || d_fill[k] !== 3'd0) begin
        failures++;
        $display("FAIL clear_collision[%0d] got out=%b cnt=%0d fill=%0d exp all 0", k, d_out[k], d_cnt[k], d_fill[k]);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'(i != 1));
    checks++;
    if (d_out[0] !== 1'b1 || d_cnt[0] !== 8'd1 || d_fill[0] !== 3'd4) begin
      failures++;
      $display("FAIL clear_rematch got out=%b cnt=%0d fill=%0d exp out=1 cnt=1 fill=4", d_out[0], d_cnt[0], d_fill[0]);
    end
  endtask

  task automatic test_random();
    bit r, c, v;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 1);
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      step(r, c, v, ($urandom_range(0, 99) < 60));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_out[k] !== m_out[k] || d_cnt[k] !== 8'(m_cnt[k]) || d_fill[k] !== 3'(exp_fill(k))) begin
          failures++;
          $display("FAIL random[%0d] cyc%0d got out=%b cnt=%0d fill=%0d exp out=%b cnt=%0d fill=%0d",
                   k, i, d_out[k], d_cnt[k], d_fill[k], m_out[k], m_cnt[k], exp_fill(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_b = 1'b0;
    m_pat[0] = 4'b1011; m_ov[0] = 1'b1; m_max[0] = 255;
    m_pat[1] = 4'b1011; m_ov[1] = 1'b0; m_max[1] = 255;
    m_pat[2] = 4'b1111; m_ov[2] = 1'b1; m_max[2] = 3;
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; m_out[k] = 1'b0; m_cnt[k] = 0;
    end
    test_reset();
    test_streams();
    test_bubbles();
    test_saturation();
    test_clear_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
